// File: rtl/riscv_pipe_pkg.sv
// Shared RV32I pipeline definitions: data width, register index width and
// the encoding of the writeback result select.
package riscv_pipe_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic RESULT_SRC_ALU = 1'b0;
  localparam logic RESULT_SRC_MEM = 1'b1;
endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, combinational read.
// Contents are not reset; writes are blocked while rst is low.
module data_memory
  import riscv_pipe_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   writeData,
  output logic [XLEN-1:0]   readData
);

  logic [XLEN-1:0] mem [DEPTH];

  // rst is sampled here so a store at an edge coincident with reset is dropped
  always_ff @(posedge clk) begin
    if (writeEn && rst) begin
      mem[addr] <= writeData;
    end
  end

  assign readData = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// RV32I memory-access stage: data memory access, MEM/WB register and result mux.
// Define MEMORY_STAGE_MISALIGN_CHECK_EN to flag and suppress misaligned accesses.
module memory_stage
  import riscv_pipe_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       ALU_Result_M,
  input  logic [XLEN-1:0]       WriteDataM,
  input  logic [XLEN-1:0]       PCPlus4M,
  input  logic [REG_ADDR_W-1:0] RD_M,
  input  logic                  RegWriteM,
  input  logic                  MemWriteM,
  input  logic                  ResultSrcM,
  output logic [XLEN-1:0]       ALUResultW,
  output logic [XLEN-1:0]       ReadDataW,
  output logic [XLEN-1:0]       PCPlus4W,
  output logic [REG_ADDR_W-1:0] RD_W,
  output logic                  RegWriteW,
  output logic                  ResultSrcW,
  output logic [XLEN-1:0]       ResultW,
  output logic                  MisalignW
);

  logic [ADDR_W-1:0] wordIdx;
  logic [XLEN-1:0]   readDataM;
  logic              isLoadM;
  logic              misalignM;
  logic              storeEnM;
  logic              regWriteEffM;

  assign wordIdx = ALU_Result_M[ADDR_W+1:2];
  assign isLoadM = (ResultSrcM == RESULT_SRC_MEM);

`ifdef MEMORY_STAGE_MISALIGN_CHECK_EN
  assign misalignM    = (ALU_Result_M[1:0] != 2'b00) && (MemWriteM || isLoadM);
  assign storeEnM     = MemWriteM && !misalignM;
  // A misaligned load must never reach the register file
  assign regWriteEffM = RegWriteM && !(misalignM && isLoadM);
`else
  assign misalignM    = 1'b0;
  assign storeEnM     = MemWriteM;
  assign regWriteEffM = RegWriteM;
`endif

  data_memory #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_data_memory (
    .clk      (clk),
    .rst      (rst),
    .writeEn  (storeEnM),
    .addr     (wordIdx),
    .writeData(WriteDataM),
    .readData (readDataM)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RD_W       <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= RESULT_SRC_ALU;
      MisalignW  <= 1'b0;
    end else begin
      ALUResultW <= ALU_Result_M;
      ReadDataW  <= readDataM;
      PCPlus4W   <= PCPlus4M;
      RD_W       <= RD_M;
      RegWriteW  <= regWriteEffM;
      ResultSrcW <= ResultSrcM;
      MisalignW  <= misalignM;
    end
  end

  assign ResultW = (ResultSrcW == RESULT_SRC_MEM) ? ReadDataW : ALUResultW;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage; expectations follow MEMORY_STAGE_MISALIGN_CHECK_EN.
module tb_memory_stage;

  logic        clk;
  logic        rst;
  logic [31:0] ALU_Result_M;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;
  logic [4:0]  RD_M;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        ResultSrcM;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic [4:0]  RD_W;
  logic        RegWriteW;
  logic        ResultSrcW;
  logic [31:0] ResultW;
  logic        MisalignW;

  int testCount = 0;
  int failCount = 0;

`ifdef MEMORY_STAGE_MISALIGN_CHECK_EN
  localparam logic        MIS_ON      = 1'b1;
  localparam logic [31:0] WORD8_AFTER = 32'h0000_0000;
`else
  localparam logic        MIS_ON      = 1'b0;
  localparam logic [31:0] WORD8_AFTER = 32'hFFFF_FFFF;
`endif

  memory_stage dut (
    .clk         (clk),
    .rst         (rst),
    .ALU_Result_M(ALU_Result_M),
    .WriteDataM  (WriteDataM),
    .PCPlus4M    (PCPlus4M),
    .RD_M        (RD_M),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .ALUResultW  (ALUResultW),
    .ReadDataW   (ReadDataW),
    .PCPlus4W    (PCPlus4W),
    .RD_W        (RD_W),
    .RegWriteW   (RegWriteW),
    .ResultSrcW  (ResultSrcW),
    .ResultW     (ResultW),
    .MisalignW   (MisalignW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = 0x%08h", tag, obs);
    end
  endtask

  // Present one instruction in MEM, then sample just after the capturing edge
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] pc4, input logic [4:0] rd,
                       input logic regWr, input logic memWr, input logic resSrc);
    ALU_Result_M = addr;
    WriteDataM   = wdata;
    PCPlus4M     = pc4;
    RD_M         = rd;
    RegWriteM    = regWr;
    MemWriteM    = memWr;
    ResultSrcM   = resSrc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    ALU_Result_M = '0; WriteDataM = '0; PCPlus4M = '0; RD_M = '0;
    RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 1'b0;
    @(posedge clk); #1;
    check("reset ResultW", ResultW, 32'h0);
    check("reset RD_W", {27'd0, RD_W}, 32'd0);
    check("reset RegWriteW", {31'd0, RegWriteW}, 32'd0);
    rst = 1'b1;

    // initialise the words touched later
    issue(32'h20, 32'h0, 32'h4, 5'd0, 1'b0, 1'b1, 1'b0);
    issue(32'h00, 32'h0, 32'h8, 5'd0, 1'b0, 1'b1, 1'b0);

    // store then load of the same word
    issue(32'h10, 32'hDEADBEEF, 32'hC, 5'd0, 1'b0, 1'b1, 1'b0);
    issue(32'h10, 32'h0, 32'h10, 5'd3, 1'b1, 1'b0, 1'b1);
    check("lw ReadDataW", ReadDataW, 32'hDEADBEEF);
    check("lw ResultW", ResultW, 32'hDEADBEEF);
    check("lw RD_W", {27'd0, RD_W}, 32'd3);

    // ALU passthrough
    issue(32'h1234, 32'h0, 32'h40, 5'd7, 1'b1, 1'b0, 1'b0);
    check("alu ResultW", ResultW, 32'h1234);
    check("alu RD_W", {27'd0, RD_W}, 32'd7);
    check("alu RegWriteW", {31'd0, RegWriteW}, 32'd1);
    check("alu PCPlus4W", PCPlus4W, 32'h40);
    check("alu ResultSrcW", {31'd0, ResultSrcW}, 32'd0);
    issue(32'h10, 32'h0, 32'h44, 5'd3, 1'b1, 1'b0, 1'b1);
    check("mem unchanged", ResultW, 32'hDEADBEEF);

    // address wrap modulo DEPTH words
    issue(32'h100, 32'hA5A5A5A5, 32'h48, 5'd0, 1'b0, 1'b1, 1'b0);
    issue(32'h000, 32'h0, 32'h4C, 5'd2, 1'b1, 1'b0, 1'b1);
    check("wrap ResultW", ResultW, 32'hA5A5A5A5);

    // store held under reset, with the outputs cleared asynchronously
    ALU_Result_M = 32'h20; WriteDataM = 32'h55; PCPlus4M = 32'h50; RD_M = 5'd5;
    RegWriteM = 1'b1; MemWriteM = 1'b1; ResultSrcM = 1'b0;
    rst = 1'b0;
    #1;
    check("async ResultW", ResultW, 32'h0);
    check("async RegWriteW", {31'd0, RegWriteW}, 32'd0);
    check("async PCPlus4W", PCPlus4W, 32'h0);
    @(posedge clk); #1;
    check("held RD_W", {27'd0, RD_W}, 32'd0);
    ALU_Result_M = 32'h20; WriteDataM = 32'h0; PCPlus4M = 32'h54; RD_M = 5'd9;
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post-rst RD_W", {27'd0, RD_W}, 32'd9);
    check("post-rst RegWriteW", {31'd0, RegWriteW}, 32'd1);
    check("rst store dropped", ResultW, 32'h0);

    // misaligned store and load
    issue(32'h22, 32'hFFFFFFFF, 32'h58, 5'd0, 1'b0, 1'b1, 1'b0);
    check("mis sw MisalignW", {31'd0, MisalignW}, {31'd0, MIS_ON});
    issue(32'h20, 32'h0, 32'h5C, 5'd4, 1'b1, 1'b0, 1'b1);
    check("mis lw clear MisalignW", {31'd0, MisalignW}, 32'd0);
    check("mis word8 ReadDataW", ReadDataW, WORD8_AFTER);
    issue(32'h21, 32'h0, 32'h60, 5'd4, 1'b1, 1'b0, 1'b1);
    check("mis lw RegWriteW", {31'd0, RegWriteW}, {31'd0, ~MIS_ON});
    check("mis lw MisalignW", {31'd0, MisalignW}, {31'd0, MIS_ON});
    issue(32'h0, 32'h0, 32'h64, 5'd0, 1'b0, 1'b0, 1'b0);
    check("bubble MisalignW", {31'd0, MisalignW}, 32'd0);
    check("bubble RegWriteW", {31'd0, RegWriteW}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline, directly downstream of the execute stage.
- Consumes the EX/MEM pipeline register outputs and performs the data-memory load or store.
- Holds the MEM/WB pipeline register and drives the writeback result (ResultW) back to the forwarding muxes and the register file.
- Word-only loads and stores (lw/sw).

Parameters:
- DEPTH, 64, number of 32-bit words in data memory (power of two).
- ADDR_W, 6, word-index width; must equal log2(DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- ALU_Result_M  in  32  byte address for load/store; ALU result for non-memory ops
- WriteDataM  in  32  store data
- PCPlus4M  in  32  PC+4 of the instruction in MEM
- RD_M  in  5  destination register
- RegWriteM  in  1  register-write enable
- MemWriteM  in  1  store enable
- ResultSrcM  in  1  0 = ALU result, 1 = load data
- ALUResultW  out  32  registered ALU result
- ReadDataW  out  32  registered load data
- PCPlus4W  out  32  registered PC+4
- RD_W  out  5  registered destination register
- RegWriteW  out  1  registered register-write enable
- ResultSrcW  out  1  registered result select
- ResultW  out  32  combinational: ResultSrcW ? ReadDataW : ALUResultW
- MisalignW  out  1  misaligned-access flag (optional feature; tied 0 otherwise)

Behaviour:
- Word index = ALU_Result_M[ADDR_W+1:2]. Address bits above ADDR_W+1 are ignored, so accesses wrap modulo DEPTH words. Bits [1:0] are ignored unless the optional feature is enabled.
- Read: combinational, mem[index] in the same cycle, available to the MEM/WB register at the next posedge.
- Write: on posedge clk, when MemWriteM=1 and rst=1, mem[index] <= WriteDataM.
- Same-cycle load and store to the same index cannot occur; a single instruction occupies MEM per cycle.
- A load in the cycle after a store to the same index returns the new data.
- Memory array is not reset. Contents are undefined at power-up; the bench must initialise before loading.
- While rst=0, no memory write occurs, including a store present at an edge coincident with reset assertion.
- MEM/WB register, one-cycle latency:
  - On posedge with rst=1, all W outputs take their M-side values; ReadDataW takes mem[index].
  - On rst falling (asynchronous), ALUResultW, ReadDataW, PCPlus4W = 0; RD_W = 0; RegWriteW, ResultSrcW, MisalignW = 0; therefore ResultW = 0.
  - Reset mid-operation discards the in-flight instruction; nothing is written to the register file.
- ResultW is purely combinational from W registers; no extra latency on the forwarding path.
- No stall or flush inputs: the stage advances every cycle.
- Bubbles arrive as RegWriteM=0, MemWriteM=0 and pass through harmlessly.

Optional Feature:
- Macro: MEMORY_STAGE_MISALIGN_CHECK_EN.
- Enabled:
  - A store with ALU_Result_M[1:0] != 0 is suppressed (no memory write).
  - MisalignW is set at the next posedge for any access (MemWriteM=1 or ResultSrcM=1) with nonzero low bits, and stays set for exactly that instruction's W cycle.
  - A misaligned load forces RegWriteW=0, so no register write occurs.
- Disabled:
  - Low address bits are ignored and the access proceeds at the word index.
  - MisalignW is tied to 0.

Decomposition:
- Shared package riscv_pipe_pkg: XLEN=32, REG_ADDR_W=5, RESULT_SRC_ALU=1'b0, RESULT_SRC_MEM=1'b1.
- One sub-module, data_memory: DEPTH/ADDR_W parameters, synchronous write, combinational read, write enable gated by rst.
- memory_stage instantiates data_memory and contains the MEM/WB register and the result mux.

Test Plan:
- Reset: drive rst=0 mid-run with RegWriteM=1, RD_M=5 -> all W outputs 0 and ResultW=0 immediately (asynchronous). On the first edge after release, the outputs follow M inputs.
- Store then load: sw 0xDEADBEEF to addr 0x10 in cycle n, lw addr 0x10 with ResultSrcM=1 in cycle n+1 -> at cycle n+2, ReadDataW=0xDEADBEEF and ResultW=0xDEADBEEF.
- ALU passthrough: ALU_Result_M=0x1234, ResultSrcM=0, RegWriteM=1, RD_M=7, PCPlus4M=0x40 -> next cycle ResultW=0x1234, RD_W=7, RegWriteW=1, PCPlus4W=0x40. Memory is unchanged.
- Wrap: sw 0xA5A5A5A5 to addr 0x100 (DEPTH=64) -> lw addr 0x000 returns 0xA5A5A5A5.
- Store under reset: MemWriteM=1, addr 0x20, data 0x55, with rst=0 across the edge -> a later lw of 0x20 returns the pre-initialised value 0x0, not 0x55.
- Misalign (macro on): sw 0xFFFFFFFF to addr 0x22 -> MisalignW=1 for one cycle; lw of 0x20 returns the old value. Misaligned lw -> RegWriteW=0. Macro off: the same sw writes word 8 and MisalignW stays 0.
